conv2_k_mac_unit: RTL and testbench

//  Downstream consumer of a conv2 kernel weight ROM (dual-port, 256 x 16-bit, 1-cycle read latency).

---
 rtl/conv2_k_mac_unit.sv | 141 ++++++++++++++
 tb/tb_conv2_k_mac_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_k_mac_unit.sv
// conv2 kernel MAC: streams weight/activation pairs from dual-port memories and accumulates one Q8.8 output pixel.
// Optional build macro CONV2_RELU_EN fuses a ReLU after saturation.
module conv2_k_mac_unit #(
  parameter int N_TAPS    = 256,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  output logic              busy,
  output logic [ADDR_W-1:0] k_addr_a,
  output logic [ADDR_W-1:0] k_addr_b,
  input  logic [DATA_W-1:0] k_q_a,
  input  logic [DATA_W-1:0] k_q_b,
  output logic [ADDR_W-1:0] act_addr_a,
  output logic [ADDR_W-1:0] act_addr_b,
  input  logic [DATA_W-1:0] act_q_a,
  input  logic [DATA_W-1:0] act_q_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(N_TAPS / 2 - 1);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

  state_t                    state, state_d;
  logic [ADDR_W-1:0]         pair;
  logic [1:0]                drain_cnt;
  logic                      rom_vld, s1_vld, s2_vld;
  logic signed [DATA_W-1:0]  s1_ka, s1_kb, s1_aa, s1_ab;
  logic signed [PROD_W-1:0]  s2_pa, s2_pb;
  logic signed [ACC_W-1:0]   acc, acc_next, shifted;
  logic [DATA_W-1:0]         result;
  logic                      accept;
  logic                      to_out;

  assign accept     = (state == IDLE) && start;
  assign to_out     = (state == DRAIN) && (drain_cnt == 2'd2);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == OUT);
  assign act_addr_a = k_addr_a;
  assign act_addr_b = k_addr_b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (pair == LAST_PAIR) state_d = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset here is synchronous, checked inside the clocked block.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Only a valid stage-2 product pair may move the accumulator.
  always_comb begin
    acc_next = acc;
    if (s2_vld)
      acc_next = acc + {{(ACC_W-PROD_W){s2_pa[PROD_W-1]}}, s2_pa}
                     + {{(ACC_W-PROD_W){s2_pb[PROD_W-1]}}, s2_pb};
  end

  always_comb begin
    shifted = acc_next >>> FRAC_BITS;
    if (&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1])
      result = shifted[DATA_W-1:0];
    else
      result = shifted[ACC_W-1] ? SAT_MIN : SAT_MAX;
`ifdef CONV2_RELU_EN
    if (result[DATA_W-1]) result = '0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pair      <= '0;
      drain_cnt <= '0;
      k_addr_a  <= '0;
      k_addr_b  <= '0;
      rom_vld   <= 1'b0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      s1_ka     <= '0;
      s1_kb     <= '0;
      s1_aa     <= '0;
      s1_ab     <= '0;
      s2_pa     <= '0;
      s2_pb     <= '0;
      acc       <= '0;
      out_data  <= '0;
    end else begin
      // Memory data lands one cycle after its address; the valid bits track it through the pipe.
      rom_vld <= (state == FETCH);
      s1_vld  <= rom_vld;
      s2_vld  <= s1_vld;
      s1_ka   <= k_q_a;
      s1_kb   <= k_q_b;
      s1_aa   <= act_q_a;
      s1_ab   <= act_q_b;
      s2_pa   <= s1_ka * s1_aa;
      s2_pb   <= s1_kb * s1_ab;

      if (accept) begin
        acc      <= {{(ACC_W-DATA_W-FRAC_BITS){bias[DATA_W-1]}}, bias, {FRAC_BITS{1'b0}}};
        pair     <= '0;
        k_addr_a <= '0;
        k_addr_b <= ADDR_W'(1);
      end else begin
        acc <= acc_next;
      end

      if (state == FETCH && pair != LAST_PAIR) begin
        pair     <= pair + ADDR_W'(1);
        k_addr_a <= k_addr_a + ADDR_W'(2);
        k_addr_b <= k_addr_b + ADDR_W'(2);
      end

      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                drain_cnt <= '0;

      if (to_out) out_data <= result;
    end
  end

endmodule

// File: tb/tb_conv2_k_mac_unit.sv
// Self-checking bench for conv2_k_mac_unit: memory models, directed vector table, corner sequences, random pixels.
module tb_conv2_k_mac_unit;

  localparam int N_TAPS = 256;
  // Edges after the start edge T0 until out_valid is seen (valid during the cycle closing at T132).
  localparam int LAT = N_TAPS / 2 + 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bias  = '0;
  logic        busy;
  logic [7:0]  k_addr_a, k_addr_b, act_addr_a, act_addr_b;
  logic [15:0] k_q_a, k_q_b, act_q_a, act_q_b;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [15:0] w_mem [N_TAPS];
  logic [15:0] a_mem [N_TAPS];

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] first_a, first_b, last_a, last_b;
  bit         addr_ok, stable_ok;
  logic       hs_busy, hs_valid;

  always #5 clock = ~clock;

  conv2_k_mac_unit dut (
    .clock(clock), .reset(reset), .start(start), .bias(bias), .busy(busy),
    .k_addr_a(k_addr_a), .k_addr_b(k_addr_b), .k_q_a(k_q_a), .k_q_b(k_q_b),
    .act_addr_a(act_addr_a), .act_addr_b(act_addr_b), .act_q_a(act_q_a), .act_q_b(act_q_b),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always @(posedge clock) begin
    k_q_a   <= w_mem[k_addr_a];
    k_q_b   <= w_mem[k_addr_b];
    act_q_a <= a_mem[act_addr_a];
    act_q_b <= a_mem[act_addr_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] ref_pixel(input logic [15:0] b);
    longint s;
    s = longint'($signed(b)) * 256;
    for (int i = 0; i < N_TAPS; i++)
      s += longint'($signed(w_mem[i])) * longint'($signed(a_mem[i]));
    s = s >>> 8;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`ifdef CONV2_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic fill(input logic [15:0] w, input logic [15:0] a);
    for (int i = 0; i < N_TAPS; i++) begin
      w_mem[i] = w;
      a_mem[i] = a;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_TAPS; i++) begin
      w_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
      a_mem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    end
  endtask

  // Returns #1 after the start edge T0.
  task automatic do_start(input logic [15:0] b);
    @(negedge clock);
    bias  = b;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (!out_valid && lat < 400) begin
      if (act_addr_a !== k_addr_a || act_addr_b !== k_addr_b) addr_ok = 0;
      if (lat == 0)   begin first_a = k_addr_a; first_b = k_addr_b; end
      if (lat == 127) begin last_a  = k_addr_a; last_b  = k_addr_b; end
      if (lat == 128 && k_addr_a !== 8'd254) addr_ok = 0;
      @(posedge clock);
      #1 lat++;
    end
    if (lat >= 400) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Handshake with a random-or-fixed stall; a start pulse rides on the handshake cycle.
  task automatic finish_pixel(input int stall, output logic [15:0] d);
    d = out_data;
    stable_ok = 1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clock);
      #1 if (out_data !== d || out_valid !== 1'b1 || busy !== 1'b1) stable_ok = 0;
    end
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    start    = 1'b0;
    hs_busy  = busy;
    hs_valid = out_valid;
  endtask

  task automatic run_pixel(input logic [15:0] b, input int stall, output logic [15:0] d, output int lat);
    addr_ok = 1;
    lat = 0;
    do_start(b);
    wait_valid(lat);
    finish_pixel(stall, d);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] d;
  int          lat;
  bit          quiet;

  initial begin
    vecs[0] = '{16'h0100, 16'h0010, 16'h0000, 16'h1000};
    vecs[1] = '{16'h0100, 16'h0010, 16'h0100, 16'h1100};
    vecs[2] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF};
`ifdef CONV2_RELU_EN
    vecs[3] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000};
`else
    vecs[3] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h8000};
`endif
    vecs[4] = '{16'h0100, 16'h0100, 16'h0000, 16'h7FFF};

    fill(16'h0000, 16'h0000);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_k_addr_a", 32'(k_addr_a), 32'd0);
    check("reset_k_addr_b", 32'(k_addr_b), 32'd0);

    for (int i = 0; i < 5; i++) begin
      fill(vecs[i].w, vecs[i].a);
      run_pixel(vecs[i].b, 0, d, lat);
      check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_hs_busy", i), 32'(hs_busy), 32'd0);
      if (i == 0) begin
        check("addr_first_a", 32'(first_a), 32'd0);
        check("addr_first_b", 32'(first_b), 32'd1);
        check("addr_last_a", 32'(last_a), 32'd254);
        check("addr_last_b", 32'(last_b), 32'd255);
        check("addr_act_match_hold", 32'(addr_ok), 32'd1);
      end
    end

    // Consumer stalls 5 cycles after out_valid, accepts on the 6th.
    fill(16'h0100, 16'h0010);
    run_pixel(16'h0000, 5, d, lat);
    check("stall_stable", 32'(stable_ok), 32'd1);
    check("stall_data", 32'(d), 32'h1000);
    check("stall_busy_after", 32'(hs_busy), 32'd0);
    check("stall_valid_after", 32'(hs_valid), 32'd0);

    // Start pulse during FETCH at pair 40 is ignored.
    addr_ok = 1;
    lat = 0;
    do_start(16'h0000);
    repeat (40) begin @(posedge clock); #1 lat++; end
    check("mid_start_addr_before", 32'(k_addr_a), 32'd80);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat++;
    check("mid_start_addr_after", 32'({k_addr_b, k_addr_a}), 32'({8'd83, 8'd82}));
    wait_valid(lat);
    check("mid_start_latency", 32'(lat), 32'(LAT));
    finish_pixel(0, d);
    check("mid_start_data", 32'(d), 32'h1000);
    quiet = 1;
    repeat (150) begin
      @(posedge clock);
      #1 if (out_valid || busy) quiet = 0;
    end
    check("mid_start_single_result", 32'(quiet), 32'd1);

    // Reset at pair 60 discards the pixel; a fresh start then saturates cleanly.
    fill(16'h7FFF, 16'h7FFF);
    do_start(16'h0000);
    repeat (60) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_addr", 32'(k_addr_a), 32'd0);
    quiet = 1;
    repeat (10) begin
      @(posedge clock);
      #1 if (out_valid || busy) quiet = 0;
    end
    check("midreset_no_output", 32'(quiet), 32'd1);
    fill(16'h0100, 16'h0100);
    run_pixel(16'h0000, 0, d, lat);
    check("midreset_data", 32'(d), 32'h7FFF);
    check("midreset_latency", 32'(lat), 32'(LAT));

    // Randomised pixels against the arithmetic reference.
    for (int r = 0; r < 4; r++) begin
      logic [15:0] b, exp;
      fill_random();
      b   = 16'($urandom);
      exp = ref_pixel(b);
      run_pixel(b, int'($urandom_range(0, 3)), d, lat);
      check($sformatf("rand%0d_data", r), 32'(d), 32'(exp));
      check($sformatf("rand%0d_latency", r), 32'(lat), 32'(LAT));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
